// File: rtl/module_pc_sequencer_if.sv
// Jump-request handshake from decode and the PC control bus toward the PC register.
interface module_pc_sequencer_if #(
  parameter int ANCHO = 4
);
  logic             jmp_valid_i;
  logic [ANCHO-1:0] jmp_addr_i;
  logic             jmp_ready_o;
  logic [1:0]       pc_op_o;
  logic [ANCHO-1:0] pc_addr_o;
  logic             pc_we_o;

  // sequencer side
  modport slave (
    input  jmp_valid_i, jmp_addr_i,
    output jmp_ready_o, pc_op_o, pc_addr_o, pc_we_o
  );

  // decode / PC side
  modport master (
    output jmp_valid_i, jmp_addr_i,
    input  jmp_ready_o, pc_op_o, pc_addr_o, pc_we_o
  );
endinterface

// File: rtl/module_pc_sequencer.sv
// PC sequencer: run/pause/single-step control FSM that issues PC op codes and a
// one-cycle apply strobe, with a one-entry buffer holding a pending jump target.
module module_pc_sequencer #(
  parameter int ANCHO    = 4,
  parameter int TICK_CNT = 10_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear_i,
  input  logic                        run_i,
  input  logic                        halt_i,
  input  logic                        step_i,
  output logic [1:0]                  state_o,
  module_pc_sequencer_if.slave        bus
);
  localparam int CW = (TICK_CNT > 2) ? $clog2(TICK_CNT) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_CNT - 1);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_HOLD = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_JMP  = 2'b11;

  logic [1:0]       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             pending, pending_n;
  logic             clr_pend, clr_pend_n;
  logic             ready, ready_n;
  logic [ANCHO-1:0] addr, addr_n;
  logic [1:0]       op, op_n;
  logic             we, we_n;
  logic             strobe;
  logic             accept;

  // next-state, counter and strobe decision; every output is registered for next cycle
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    strobe     = 1'b0;
    clr_pend_n = 1'b0;
    op_n       = OP_HOLD;
    we_n       = 1'b0;
    if (clear_i) begin
      state_n    = S_IDLE;
      cnt_n      = '0;
      clr_pend_n = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (!halt_i && run_i) begin
            state_n = S_RUN;
            cnt_n   = '0;
          end else if (!halt_i && step_i) begin
            state_n = S_PAUSE;
            strobe  = 1'b1;
          end
        end
        S_RUN: begin
          // leaving RUN suppresses the strobe even on terminal count
          if (halt_i || !run_i) begin
            state_n = S_PAUSE;
            cnt_n   = '0;
          end else if (cnt == TERM) begin
            cnt_n  = '0;
            strobe = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_PAUSE: begin
          if (!halt_i && run_i) begin
            state_n = S_RUN;
            cnt_n   = '0;
          end else if (step_i) begin
            strobe = 1'b1;
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      endcase
    end

    // op code follows the state it will be shown with; strobes override
    op_n = (state_n == S_IDLE) ? OP_CLR : OP_HOLD;
    if (!clear_i && clr_pend) begin
      op_n = OP_CLR;
      we_n = 1'b1;
    end
    if (strobe) begin
      op_n = pending ? OP_JMP : OP_INC;
      we_n = 1'b1;
    end
  end

  // jump buffer: pending reflects the state at cycle start, so a same-cycle
  // accept never turns the current strobe into a jump
  always_comb begin
    accept    = bus.jmp_valid_i && ready && !clear_i;
    pending_n = pending;
    ready_n   = !pending;
    addr_n    = addr;
    if (clear_i) begin
      pending_n = 1'b0;
      ready_n   = 1'b1;
    end else if (accept) begin
      pending_n = 1'b1;
      ready_n   = 1'b0;
      addr_n    = bus.jmp_addr_i;
    end else if (strobe && pending) begin
      pending_n = 1'b0;
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pending  <= 1'b0;
      clr_pend <= 1'b0;
      ready    <= 1'b1;
      addr     <= '0;
      op       <= OP_CLR;
      we       <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pending  <= pending_n;
      clr_pend <= clr_pend_n;
      ready    <= ready_n;
      addr     <= addr_n;
      op       <= op_n;
      we       <= we_n;
    end
  end

  assign state_o         = state;
  assign bus.jmp_ready_o = ready;
  assign bus.pc_op_o     = op;
  assign bus.pc_addr_o   = addr;
  assign bus.pc_we_o     = we;
endmodule
